// File: rtl/bxb_pkg.sv
// Shared types and constants for the B x B request arbiter.
// Vectors pack four signed 32-bit lanes, lane 1 in the low bits.
package bxb_pkg;

    localparam int LANE_W = 32;
    localparam int LANES  = 4;
    localparam int VEC_W  = LANE_W * LANES;

    typedef logic [VEC_W-1:0] vec_t;
    typedef logic             req_id_t;

    function automatic logic [LANE_W-1:0] lane(input vec_t v, input int i);
        return v[i*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/bxb_result_fifo.sv
// Synchronous result FIFO; pointers carry one extra wrap bit.
// Pops of an empty FIFO are dropped here as well as upstream.
module bxb_result_fifo
    import bxb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  vec_t din,
    output vec_t dout,
    output logic empty,
    output logic full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    vec_t        mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/bxb_arbiter.sv
// Two-requester round-robin front end for a fixed-latency B x B datapath.
// Credits reserve a result slot at accept time so the FIFOs never overflow.
module bxb_arbiter
    import bxb_pkg::*;
#(
    parameter int LAT        = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  vec_t              req0_x,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  vec_t              req1_x,
    output logic [LANE_W-1:0] dp_x1,
    output logic [LANE_W-1:0] dp_x2,
    output logic [LANE_W-1:0] dp_x3,
    output logic [LANE_W-1:0] dp_x4,
    input  logic [LANE_W-1:0] dp_r1,
    input  logic [LANE_W-1:0] dp_r2,
    input  logic [LANE_W-1:0] dp_r3,
    input  logic [LANE_W-1:0] dp_r4,
    output logic              res0_valid,
    input  logic              res0_ready,
    output vec_t              res0_r,
    output logic              res1_valid,
    input  logic              res1_ready,
    output vec_t              res1_r
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CRED_INIT = CW'(FIFO_DEPTH);

    logic [CW-1:0] credit0, credit1;
    logic          last1;
    logic          elig0, elig1, grant0, grant1, accept;
    logic          pop0, pop1, push0, push1;
    logic          empty0, empty1, full0, full1;
    vec_t          dp_q, r_vec;
    logic          tag_v  [LAT];
    req_id_t       tag_id [LAT];

    // last1 is set after reset so requester 0 wins the first contention
    assign elig0  = req0_valid && (credit0 != '0);
    assign elig1  = req1_valid && (credit1 != '0);
    assign grant0 = !rst && elig0 && (!elig1 || last1);
    assign grant1 = !rst && elig1 && (!elig0 || !last1);
    assign accept = grant0 || grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            last1 <= 1'b1;
            dp_q  <= '0;
        end else if (accept) begin
            last1 <= grant1;
            dp_q  <= grant1 ? req1_x : req0_x;
        end
    end

    assign dp_x1 = lane(dp_q, 0);
    assign dp_x2 = lane(dp_q, 1);
    assign dp_x3 = lane(dp_q, 2);
    assign dp_x4 = lane(dp_q, 3);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) tag_v[i] <= 1'b0;
        end else begin
            tag_v[0] <= accept;
            for (int i = 1; i < LAT; i++) tag_v[i] <= tag_v[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0] <= grant1;
        for (int i = 1; i < LAT; i++) tag_id[i] <= tag_id[i-1];
    end

    assign r_vec = {dp_r4, dp_r3, dp_r2, dp_r1};
    assign push0 = tag_v[LAT-1] && (tag_id[LAT-1] == 1'b0);
    assign push1 = tag_v[LAT-1] && (tag_id[LAT-1] == 1'b1);
    assign pop0  = res0_ready && !empty0;
    assign pop1  = res1_ready && !empty1;

    always_ff @(posedge clk) begin
        if (rst) begin
            credit0 <= CRED_INIT;
            credit1 <= CRED_INIT;
        end else begin
            if (grant0 && !pop0) credit0 <= credit0 - 1'b1;
            else if (!grant0 && pop0) credit0 <= credit0 + 1'b1;
            if (grant1 && !pop1) credit1 <= credit1 - 1'b1;
            else if (!grant1 && pop1) credit1 <= credit1 + 1'b1;
        end
    end

    bxb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk   (clk),
        .rst   (rst),
        .push  (push0),
        .pop   (pop0),
        .din   (r_vec),
        .dout  (res0_r),
        .empty (empty0),
        .full  (full0)
    );

    bxb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk   (clk),
        .rst   (rst),
        .push  (push1),
        .pop   (pop1),
        .din   (r_vec),
        .dout  (res1_r),
        .empty (empty1),
        .full  (full1)
    );

    assign res0_valid = !empty0;
    assign res1_valid = !empty1;

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push0 && full0));
            assert (!(push1 && full1));
        end
    end

endmodule

// File: tb/tb_bxb_arbiter.sv
// Randomized bench for bxb_arbiter against a queue-level model,
// plus directed scenarios with hand-computed expectations.
module tb_bxb_arbiter;
    import bxb_pkg::*;

    localparam int LAT   = 3;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rv [2];
    vec_t        rx [2];
    logic        rrdy [2];
    logic        req0_ready, req1_ready;
    logic [31:0] dp_x1, dp_x2, dp_x3, dp_x4;
    logic [31:0] dp_r1, dp_r2, dp_r3, dp_r4;
    logic        res0_valid, res1_valid;
    vec_t        res0_r, res1_r;
    vec_t        dpx_vec;
    vec_t        hist [LAT-1];

    always #5 clk = ~clk;

    bxb_arbiter #(.LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (rv[0]),
        .req0_ready (req0_ready),
        .req0_x     (rx[0]),
        .req1_valid (rv[1]),
        .req1_ready (req1_ready),
        .req1_x     (rx[1]),
        .dp_x1      (dp_x1),
        .dp_x2      (dp_x2),
        .dp_x3      (dp_x3),
        .dp_x4      (dp_x4),
        .dp_r1      (dp_r1),
        .dp_r2      (dp_r2),
        .dp_r3      (dp_r3),
        .dp_r4      (dp_r4),
        .res0_valid (res0_valid),
        .res0_ready (rrdy[0]),
        .res0_r     (res0_r),
        .res1_valid (res1_valid),
        .res1_ready (rrdy[1]),
        .res1_r     (res1_r)
    );

    // Datapath stand-in: r equals the x set LAT edges earlier
    assign dpx_vec = {dp_x4, dp_x3, dp_x2, dp_x1};
    always @(posedge clk) begin
        hist[0] <= dpx_vec;
        for (int i = 1; i < LAT-1; i++) hist[i] <= hist[i-1];
    end
    assign {dp_r4, dp_r3, dp_r2, dp_r1} = hist[LAT-2];

    typedef struct {
        int   due;
        int   id;
        vec_t x;
    } fl_t;

    fl_t  infl [$];
    vec_t mq0 [$];
    vec_t mq1 [$];
    int   m_last = 1;
    int   cyc = 0;
    vec_t m_dpx = '0;
    bit   m_init = 0;
    int   checks = 0;
    int   failures = 0;
    int   obs0, obs1;

    function automatic int credit(input int n);
        int c;
        c = DEPTH - ((n == 0) ? mq0.size() : mq1.size());
        foreach (infl[i]) if (infl[i].id == n) c--;
        return c;
    endfunction

    function automatic int winner();
        bit e0, e1;
        if (rst) return -1;
        e0 = rv[0] && credit(0) > 0;
        e1 = rv[1] && credit(1) > 0;
        if (e0 && e1) return (m_last == 0) ? 1 : 0;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        int w;
        #1;
        obs0 = int'(req0_ready);
        obs1 = int'(req1_ready);
        w = -1;
        if (m_init) begin
            w = winner();
            chk("req0_ready", req0_ready, w == 0);
            chk("req1_ready", req1_ready, w == 1);
            chk("dp_x", dpx_vec, m_dpx);
            chk("res0_valid", res0_valid, mq0.size() > 0);
            chk("res1_valid", res1_valid, mq1.size() > 0);
            if (mq0.size() > 0) chk("res0_r", res0_r, mq0[0]);
            if (mq1.size() > 0) chk("res1_r", res1_r, mq1[0]);
        end
        @(posedge clk);
        if (rst) begin
            infl.delete();
            mq0.delete();
            mq1.delete();
            m_last = 1;
            m_dpx  = '0;
            m_init = 1;
        end else begin
            if (rrdy[0] && mq0.size() > 0) void'(mq0.pop_front());
            if (rrdy[1] && mq1.size() > 0) void'(mq1.pop_front());
            while (infl.size() > 0 && infl[0].due == cyc) begin
                fl_t f;
                f = infl.pop_front();
                if (f.id == 0) mq0.push_back(f.x);
                else mq1.push_back(f.x);
            end
            if (w >= 0) begin
                infl.push_back('{due: cyc + LAT, id: w, x: rx[w]});
                m_dpx  = rx[w];
                m_last = w;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    function automatic vec_t rnd_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        rv[0] = 0; rv[1] = 0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int n0, n1, nv, g;
        vec_t sv;
        rv[0] = 0; rv[1] = 0;
        rx[0] = '0; rx[1] = '0;
        rrdy[0] = 0; rrdy[1] = 0;
        @(negedge clk);
        cycle();
        do_reset();

        // single request, literal latency and lanes
        rv[0] = 1;
        rx[0] = {32'd3, 32'd2, 32'd1, 32'd0};
        cycle();
        rv[0] = 0;
        chk("single_dp_x1", dp_x1, 0);
        chk("single_dp_x2", dp_x2, 1);
        chk("single_dp_x3", dp_x3, 2);
        chk("single_dp_x4", dp_x4, 3);
        cycle();
        chk("single_valid_e2", res0_valid, 0);
        cycle();
        chk("single_valid_e3", res0_valid, 0);
        cycle();
        chk("single_valid_e4", res0_valid, 1);
        chk("single_res0_r", res0_r, {32'd3, 32'd2, 32'd1, 32'd0});
        rrdy[0] = 1;
        cycle();

        // contention: alternating grants starting with req0
        do_reset();
        rv[0] = 1; rv[1] = 1; rrdy[0] = 1; rrdy[1] = 1;
        for (int i = 0; i < 8; i++) begin
            rx[0] = rnd_vec(); rx[1] = rnd_vec();
            cycle();
            g = obs0 ? 0 : (obs1 ? 1 : -1);
            chk("contend_grant", g, i % 2);
        end
        rv[0] = 0; rv[1] = 0;
        for (int i = 0; i < 6; i++) cycle();

        // backpressure on req0
        do_reset();
        rv[0] = 1; rv[1] = 1; rrdy[0] = 0; rrdy[1] = 1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 20; i++) begin
            rx[0] = rnd_vec(); rx[1] = rnd_vec();
            cycle();
            n0 += obs0;
            if (i >= 8) n1 += obs1;
        end
        chk("bp_req0_accepts", n0, 4);
        chk("bp_req1_late_grants", n1 >= 9, 1);

        // release one slot
        rrdy[0] = 1;
        cycle();
        rrdy[0] = 0;
        n0 = 0;
        for (int i = 0; i < 10; i++) begin
            rx[0] = rnd_vec(); rx[1] = rnd_vec();
            cycle();
            n0 += obs0;
        end
        chk("release_req0_accepts", n0, 1);

        // reset mid-flight
        do_reset();
        rv[0] = 1; rv[1] = 0; rrdy[0] = 1; rrdy[1] = 1;
        rx[0] = rnd_vec();
        cycle();
        rx[0] = rnd_vec();
        cycle();
        rst = 1; rv[0] = 0;
        cycle();
        rst = 0;
        chk("midrst_dp_x", dpx_vec, 0);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            nv += int'(res0_valid | res1_valid);
        end
        chk("midrst_no_results", nv, 0);
        rv[0] = 1; rrdy[0] = 0;
        n0 = 0;
        for (int i = 0; i < 10; i++) begin
            rx[0] = rnd_vec();
            cycle();
            n0 += obs0;
        end
        chk("midrst_credits", n0, 4);

        // signed extremes pass bit-exact
        do_reset();
        sv = {32'hFFFFFFFB, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF};
        rv[0] = 1; rx[0] = sv; rrdy[0] = 0;
        cycle();
        rv[0] = 0;
        for (int i = 0; i < LAT; i++) cycle();
        chk("signed_valid", res0_valid, 1);
        chk("signed_res0_r", res0_r, sv);
        rrdy[0] = 1;
        cycle();

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rv[0]   = ($urandom_range(0, 3) != 0);
            rv[1]   = ($urandom_range(0, 2) != 0);
            rx[0]   = rnd_vec();
            rx[1]   = rnd_vec();
            rrdy[0] = ($urandom_range(0, 2) != 0);
            rrdy[1] = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
